// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer that sits between the ALU/branch unit and
// instruction fetch. The next-pc candidate is chosen by pc_sel. It is checked
// for alignment and range before it is committed, so an illegal address never
// reaches pc. If the check fails, the sequencer parks in HALTED with a sticky
// cause code until resume or rst.
//
// Optional feature (macro PC_RAS_EN): a RAS_DEPTH-entry circular return-address
// stack. A jump (pc_sel=00) can push pc+INC_BYTES onto it, and a jump can pop
// its destination from it. Without the macro there is no stack storage,
// ras_push and ras_pop are ignored, and ras_empty is tied high.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset, highest priority
//   stall      in   hold pc this cycle (overrides pc_sel)
//   pc_sel     in   00 target/RAS top, 01 pc+INC_BYTES, 10 hold, 11 TRAP_ADDR
//   target     in   branch/jump target
//   resume     in   leave HALTED and reload RESET_ADDR
//   ras_push   in   push return address on a committed pc_sel=00 step
//   ras_pop    in   with pc_sel=00, take destination from the stack top
//   pc         out  current program counter
//   commit     out  one-cycle pulse aligned with a newly loaded pc
//   halt       out  high while HALTED
//   halt_cause out  {oor, mis}; 00 while running
//   ras_empty  out  return-address stack is empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h01000000,
   parameter logic [XLEN-1:0] ADDR_HI    = 32'h01000FFC,
   parameter logic [XLEN-1:0] ADDR_LO    = 32'h01000000,
   parameter logic [XLEN-1:0] TRAP_ADDR  = 32'h01000F00,
   parameter int              INC_BYTES  = 4,
   parameter int              ALIGN_BITS = 2,
   parameter int              RAS_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] target,
   input  logic            resume,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] pc,
   output logic            commit,
   output logic            halt,
   output logic [1:0]      halt_cause,
   output logic            ras_empty
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            commit_q, commit_d;
   logic [1:0]      cause_q, cause_d;

   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] jump_dest;   // destination for pc_sel=00
   logic [XLEN-1:0] cand;
   logic            mis, oor;
   logic            take;        // a RUN step that loads cand into pc

   assign pc_inc = pc_q + INC_VAL;   // wraps modulo 2^XLEN; range check catches it

   // ---------------------------------------------------------------------------
   // Candidate next pc and legality check
   // ---------------------------------------------------------------------------
   always_comb begin
      cand = pc_q;
      case (pc_sel)
         2'b00:   cand = jump_dest;
         2'b01:   cand = pc_inc;
         2'b10:   cand = pc_q;
         default: cand = TRAP_ADDR;
      endcase
   end

   assign mis = (cand & ALIGN_MASK) != '0;
   assign oor = (cand > ADDR_HI) || (cand < ADDR_LO);

   // ---------------------------------------------------------------------------
   // RUN/HALTED state machine
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_ADDR;
         commit_q <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         commit_q <= commit_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      commit_d = 1'b0;
      cause_d  = cause_q;
      take     = 1'b0;
      case (state_q)
         ST_RUN: begin
            // Hold (pc_sel=10) never checks, so it can never halt.
            if (!stall && (pc_sel != 2'b10)) begin
               if (mis || oor) begin
                  state_d = ST_HALTED;
                  cause_d = {oor, mis};
               end else begin
                  pc_d     = cand;
                  commit_d = 1'b1;
                  take     = 1'b1;
               end
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_d  = ST_RUN;
               pc_d     = RESET_ADDR;
               commit_d = 1'b1;
               cause_d  = 2'b00;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign pc         = pc_q;
   assign commit     = commit_q;
   assign halt       = (state_q == ST_HALTED);
   assign halt_cause = cause_q;

`ifdef PC_RAS_EN
   // ---------------------------------------------------------------------------
   // Circular return-address stack. ras_top_q points at the newest entry.
   // When the stack is full, a push moves the pointer onto the oldest entry
   // and overwrites it, so the newest RAS_DEPTH addresses are always kept.
   // ---------------------------------------------------------------------------
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ras_top_q, ras_top_d, ras_top_popped;
   logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d, ras_cnt_popped;
   logic             ras_has;
   logic             ras_we;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      ptr_dec = (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   assign ras_has   = (ras_cnt_q != '0);
   // A pop on an empty stack falls back to the ALU target.
   assign jump_dest = (ras_pop && ras_has) ? ras_mem_q[ras_top_q] : target;
   assign ras_empty = !ras_has;

   always_comb begin
      ras_top_d      = ras_top_q;
      ras_cnt_d      = ras_cnt_q;
      ras_top_popped = ras_top_q;
      ras_cnt_popped = ras_cnt_q;
      ras_we         = 1'b0;
      // Only a committed jump touches the stack; halting steps leave it alone.
      if (take && (pc_sel == 2'b00)) begin
         if (ras_pop && ras_has) begin
            ras_top_popped = ptr_dec(ras_top_q);
            ras_cnt_popped = ras_cnt_q - CNT_W'(1);
         end
         ras_top_d = ras_top_popped;
         ras_cnt_d = ras_cnt_popped;
         // Pop first, then push: push+pop together replaces the top entry.
         if (ras_push) begin
            ras_we    = 1'b1;
            ras_top_d = ptr_inc(ras_top_popped);
            ras_cnt_d = (ras_cnt_popped == CNT_W'(RAS_DEPTH)) ? ras_cnt_popped
                                                              : ras_cnt_popped + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_top_q <= ras_top_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   // Storage holds no reset; validity is tracked by ras_cnt_q alone.
   always_ff @(posedge clk) begin
      if (!rst && ras_we) begin
         ras_mem_q[ras_top_d] <= pc_inc;
      end
   end
`else
   logic unused_ras;

   assign jump_dest  = target;
   assign ras_empty  = 1'b1;
   assign unused_ras = ^{ras_push, ras_pop, take};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer with the default parameters. Each step
// drives the inputs, waits for one rising edge, and checks every output on the
// following falling edge. The return-address-stack steps are only built when
// PC_RAS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  pc_sel;
   logic [31:0] target;
   logic        resume;
   logic        ras_push;
   logic        ras_pop;
   logic [31:0] pc;
   logic        commit;
   logic        halt;
   logic [1:0]  halt_cause;
   logic        ras_empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .pc_sel     (pc_sel),
      .target     (target),
      .resume     (resume),
      .ras_push   (ras_push),
      .ras_pop    (ras_pop),
      .pc         (pc),
      .commit     (commit),
      .halt       (halt),
      .halt_cause (halt_cause),
      .ras_empty  (ras_empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks all outputs and prints one line for the transaction.
   task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic e_commit,
                             input logic e_halt, input logic [1:0] e_cause, input logic e_empty);
      $display("%-14s pc=%h commit=%0b halt=%0b cause=%02b empty=%0b",
               tag, pc, commit, halt, halt_cause, ras_empty);
      chk({tag, ".pc"},     pc,                e_pc);
      chk({tag, ".commit"}, 32'(commit),       32'(e_commit));
      chk({tag, ".halt"},   32'(halt),         32'(e_halt));
      chk({tag, ".cause"},  32'(halt_cause),   32'(e_cause));
      chk({tag, ".empty"},  32'(ras_empty),    32'(e_empty));
   endtask

   // Drives one cycle of inputs; outputs are valid at the next falling edge.
   task automatic step(input logic s_stall, input logic [1:0] s_sel, input logic [31:0] s_tgt,
                       input logic s_res, input logic s_push, input logic s_pop);
      stall    = s_stall;
      pc_sel   = s_sel;
      target   = s_tgt;
      resume   = s_res;
      ras_push = s_push;
      ras_pop  = s_pop;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; pc_sel = 2'b10; target = '0;
      resume = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      expect_out("reset", 32'h01000000, 1'b0, 1'b0, 2'b00, 1'b1);
      rst = 1'b0;

      // Sequential increments
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("inc1", 32'h01000004, 1, 0, 2'b00, 1);
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("inc2", 32'h01000008, 1, 0, 2'b00, 1);
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("inc3", 32'h0100000C, 1, 0, 2'b00, 1);
      step(0, 2'b10, 32'h0, 1, 0, 0); expect_out("hold_resume", 32'h0100000C, 0, 0, 2'b00, 1);

      // Misaligned target halts; HALTED ignores stimulus until resume
      step(0, 2'b00, 32'h01000102, 0, 0, 0); expect_out("mis_halt", 32'h0100000C, 0, 1, 2'b01, 1);
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("halted_inc", 32'h0100000C, 0, 1, 2'b01, 1);
      step(0, 2'b00, 32'h01000040, 0, 1, 1); expect_out("halted_jmp", 32'h0100000C, 0, 1, 2'b01, 1);
      step(0, 2'b01, 32'h0, 1, 0, 0); expect_out("resume1", 32'h01000000, 1, 0, 2'b00, 1);

      // Top boundary: pc=ADDR_HI then increment leaves the range
      step(0, 2'b00, 32'h01000FFC, 0, 0, 0); expect_out("jmp_hi", 32'h01000FFC, 1, 0, 2'b00, 1);
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("oor_hi", 32'h01000FFC, 0, 1, 2'b10, 1);
      step(1, 2'b01, 32'h0, 1, 0, 0); expect_out("resume_stall", 32'h01000000, 1, 0, 2'b00, 1);

      // Low boundary and the combined cause
      step(0, 2'b00, 32'h00FFFFFC, 0, 0, 0); expect_out("oor_lo", 32'h01000000, 0, 1, 2'b10, 1);
      step(0, 2'b10, 32'h0, 1, 0, 0); expect_out("resume2", 32'h01000000, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h00000001, 0, 0, 0); expect_out("both", 32'h01000000, 0, 1, 2'b11, 1);
      step(0, 2'b10, 32'h0, 1, 0, 0); expect_out("resume3", 32'h01000000, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h01000000, 0, 0, 0); expect_out("jmp_lo", 32'h01000000, 1, 0, 2'b00, 1);

      // Stall overrides pc_sel
      step(1, 2'b00, 32'h01000040, 0, 0, 0); expect_out("stall", 32'h01000000, 0, 0, 2'b00, 1);
      step(0, 2'b00, 32'h01000040, 0, 0, 0); expect_out("unstall", 32'h01000040, 1, 0, 2'b00, 1);

      // Trap vector, then reset while HALTED
      step(0, 2'b11, 32'h0, 0, 0, 0); expect_out("trap", 32'h01000F00, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h02000000, 0, 0, 0); expect_out("oor_big", 32'h01000F00, 0, 1, 2'b10, 1);
      rst = 1'b1;
      step(0, 2'b01, 32'h0, 0, 0, 0); expect_out("rst_halted", 32'h01000000, 0, 0, 2'b00, 1);
      rst = 1'b0;

`ifdef PC_RAS_EN
      step(0, 2'b00, 32'h01000010, 0, 0, 0); expect_out("ras_pre", 32'h01000010, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h01000200, 0, 1, 0); expect_out("ras_push", 32'h01000200, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h00000000, 0, 0, 1); expect_out("ras_pop", 32'h01000014, 1, 0, 2'b00, 1);
      // Five pushes at depth 4: return addresses 018, 304, 314, 324, 334
      step(0, 2'b00, 32'h01000300, 0, 1, 0); expect_out("push1", 32'h01000300, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h01000310, 0, 1, 0); expect_out("push2", 32'h01000310, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h01000320, 0, 1, 0); expect_out("push3", 32'h01000320, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h01000330, 0, 1, 0); expect_out("push4", 32'h01000330, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h01000340, 0, 1, 0); expect_out("push5", 32'h01000340, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h00000000, 0, 0, 1); expect_out("pop1", 32'h01000334, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h00000000, 0, 0, 1); expect_out("pop2", 32'h01000324, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h00000000, 0, 0, 1); expect_out("pop3", 32'h01000314, 1, 0, 2'b00, 0);
      step(0, 2'b00, 32'h00000000, 0, 0, 1); expect_out("pop4", 32'h01000304, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h01000500, 0, 0, 1); expect_out("pop_empty", 32'h01000500, 1, 0, 2'b00, 1);
`else
      // Without the stack, push/pop are ignored and pc_sel=00 takes target
      step(0, 2'b00, 32'h01000200, 0, 1, 0); expect_out("nras_push", 32'h01000200, 1, 0, 2'b00, 1);
      step(0, 2'b00, 32'h01000300, 0, 0, 1); expect_out("nras_pop", 32'h01000300, 1, 0, 2'b00, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
